// File: rtl/vector_checker.sv
// Self-checking test-vector engine: drives stored stimulus into a combinational DUT,
// samples its response after SETTLE cycles and accumulates mismatch statistics.
module vector_checker #(
    parameter  int NI     = 3,
    parameter  int NO     = 1,
    parameter  int DEPTH  = 16,
    parameter  int SETTLE = 1,
    parameter  int ERRW   = 8,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [NI+NO-1:0] wr_data,
    input  logic [AW:0]      num_vec,
    input  logic             start,
    output logic [NI-1:0]    dut_in,
    input  logic [NO-1:0]    dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERRW-1:0]  err_count,
    output logic             mismatch,
    output logic             first_err_valid,
    output logic [AW-1:0]    first_err_idx
);

    localparam int              TW           = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int              VW           = NI + NO;
    localparam logic [AW:0]     DEPTH_C      = (AW+1)'(DEPTH);
    localparam logic [TW-1:0]   TIMER_RELOAD = TW'(SETTLE - 1);
    localparam logic [ERRW-1:0] ERR_MAX      = {ERRW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [VW-1:0]   r_mem [DEPTH];
    state_t          r_state;
    logic [AW-1:0]   r_idx;
    logic [TW-1:0]   r_timer;
    logic [AW:0]     r_num;
    logic [NI-1:0]   r_dut_in;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [ERRW-1:0] r_err;
    logic            r_mis;
    logic            r_fev;
    logic [AW-1:0]   r_fei;

    logic [AW:0]     w_num;
    logic [AW-1:0]   w_next_idx;
    logic [NO-1:0]   w_exp;
    logic [NO-1:0]   w_diff;
    logic            w_mis;
    logic            w_last;
    logic            w_addr_ok;
    logic [NI-1:0]   w_first_stim;
    logic [NI-1:0]   w_next_stim;
    logic [ERRW-1:0] w_err_next;

    assign w_num        = (num_vec > DEPTH_C) ? DEPTH_C : num_vec;
    assign w_next_idx   = r_idx + AW'(1);
    assign w_exp        = r_mem[r_idx][NO-1:0];
    assign w_diff       = dut_out ^ w_exp;
    assign w_last       = ({1'b0, r_idx} == (r_num - (AW+1)'(1)));
    assign w_addr_ok    = ({1'b0, wr_addr} < DEPTH_C);
    assign w_first_stim = r_mem[{AW{1'b0}}][VW-1:NO];
    assign w_next_stim  = r_mem[w_next_idx][VW-1:NO];
    assign w_err_next   = (r_err == ERR_MAX) ? r_err : r_err + ERRW'(1);

    // Mismatch detect; case equality makes X/Z on dut_out fall into the failing branch
    always_comb begin
        w_mis = 1'b0;
        case (w_diff)
            {NO{1'b0}}: w_mis = 1'b0;
            default:    w_mis = 1'b1;
        endcase
    end

    // Vector memory write port, locked out while a run is in progress
    always_ff @(posedge clk) begin
        if (wr_en && !r_busy && w_addr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Run-control FSM with all outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= {AW{1'b0}};
            r_timer  <= {TW{1'b0}};
            r_num    <= {(AW+1){1'b0}};
            r_dut_in <= {NI{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= {ERRW{1'b0}};
            r_mis    <= 1'b0;
            r_fev    <= 1'b0;
            r_fei    <= {AW{1'b0}};
        end else begin
            r_mis <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_err  <= {ERRW{1'b0}};
                        r_fev  <= 1'b0;
                        r_fei  <= {AW{1'b0}};
                        r_done <= 1'b0;
                        r_pass <= 1'b0;
                        r_num  <= w_num;
                        if (w_num == {(AW+1){1'b0}}) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_dut_in <= w_first_stim;
                            r_idx    <= {AW{1'b0}};
                            r_timer  <= TIMER_RELOAD;
                            r_busy   <= 1'b1;
                            r_state  <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_timer != {TW{1'b0}}) begin
                        r_timer <= r_timer - TW'(1);
                    end else begin
                        if (w_mis) begin
                            r_mis <= 1'b1;
                            r_err <= w_err_next;
                            if (!r_fev) begin
                                r_fev <= 1'b1;
                                r_fei <= r_idx;
                            end
                        end
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_err == {ERRW{1'b0}}) && !w_mis;
                        end else begin
                            r_idx    <= w_next_idx;
                            r_dut_in <= w_next_stim;
                            r_timer  <= TIMER_RELOAD;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_in          = r_dut_in;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err;
    assign mismatch        = r_mis;
    assign first_err_valid = r_fev;
    assign first_err_idx   = r_fei;

endmodule

// File: tb/tb_vector_checker.sv
// Scoreboard bench for vector_checker: one instance with SETTLE=1/ERRW=8,
// one with SETTLE=3/ERRW=2, both driving the reference function y=(~b&~c)|(a&~b).
module tb_vector_checker;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en0, wr_en1, start0, start1;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic [4:0] num_vec;

    logic [2:0] dut_in0, dut_in1;
    logic       dut_out0, dut_out1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [7:0] err0;
    logic [1:0] err1;
    logic       mis0, mis1, fev0, fev1;
    logic [3:0] fei0, fei1;

    logic       sel;
    logic       m_busy, m_done, m_pass, m_mis, m_fev;
    logic [7:0] m_err;
    logic [3:0] m_fei;
    logic [2:0] m_dut_in;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] stim;
        logic       mis;
    } exp_t;
    exp_t sb_q[$];

    logic [3:0] mdl0 [16];
    logic [3:0] mdl1 [16];

    always #5 clk = ~clk;

    function automatic logic ref_f(input logic [2:0] v);
        return (~v[1] & ~v[0]) | (v[2] & ~v[1]);
    endfunction

    assign dut_out0 = ref_f(dut_in0);
    assign dut_out1 = ref_f(dut_in1);

    assign m_busy   = sel ? busy1 : busy0;
    assign m_done   = sel ? done1 : done0;
    assign m_pass   = sel ? pass1 : pass0;
    assign m_mis    = sel ? mis1  : mis0;
    assign m_fev    = sel ? fev1  : fev0;
    assign m_err    = sel ? {6'd0, err1} : err0;
    assign m_fei    = sel ? fei1  : fei0;
    assign m_dut_in = sel ? dut_in1 : dut_in0;

    vector_checker #(.NI(3), .NO(1), .DEPTH(16), .SETTLE(1), .ERRW(8)) u_vc0 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en0), .wr_addr(wr_addr),
        .wr_data(wr_data), .num_vec(num_vec), .start(start0), .dut_in(dut_in0),
        .dut_out(dut_out0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .mismatch(mis0), .first_err_valid(fev0),
        .first_err_idx(fei0)
    );

    vector_checker #(.NI(3), .NO(1), .DEPTH(16), .SETTLE(3), .ERRW(2)) u_vc1 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en1), .wr_addr(wr_addr),
        .wr_data(wr_data), .num_vec(num_vec), .start(start1), .dut_in(dut_in1),
        .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .mismatch(mis1), .first_err_valid(fev1),
        .first_err_idx(fei1)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".busy"},    32'(m_busy),   32'd0);
        check_val({tag, ".done"},    32'(m_done),   32'd0);
        check_val({tag, ".pass"},    32'(m_pass),   32'd0);
        check_val({tag, ".err"},     32'(m_err),    32'd0);
        check_val({tag, ".mis"},     32'(m_mis),    32'd0);
        check_val({tag, ".fev"},     32'(m_fev),    32'd0);
        check_val({tag, ".fei"},     32'(m_fei),    32'd0);
        check_val({tag, ".dut_in"},  32'(m_dut_in), 32'd0);
    endtask

    task automatic write_vec(input bit s, input int addr, input logic [2:0] stim, input logic e);
        @(negedge clk);
        wr_addr = addr[3:0];
        wr_data = {stim, e};
        if (s) wr_en1 = 1'b1;
        else   wr_en0 = 1'b1;
        @(negedge clk);
        wr_en0 = 1'b0;
        wr_en1 = 1'b0;
        if (s) mdl1[addr] = {stim, e};
        else   mdl0[addr] = {stim, e};
    endtask

    // Runs one test on instance s; abort_at>=0 pulls reset at that cycle, poke
    // issues a start and a memory write while the run is in progress.
    task automatic run(input bit s, input int n, input int settle, input int abort_at, input bit poke);
        int         nv, sat, exp_err, first, k;
        exp_t       e;
        logic [3:0] w;
        sel     = s;
        nv      = (n > 16) ? 16 : n;
        sat     = s ? 3 : 255;
        exp_err = 0;
        first   = -1;
        sb_q.delete();
        for (int i = 0; i < nv; i++) begin
            w      = s ? mdl1[i] : mdl0[i];
            e.stim = w[3:1];
            e.mis  = (ref_f(w[3:1]) !== w[0]);
            sb_q.push_back(e);
        end
        @(negedge clk);
        num_vec = n[4:0];
        if (s) start1 = 1'b1;
        else   start0 = 1'b1;
        @(posedge clk);
        for (int t = 0; t <= nv * settle; t++) begin
            @(negedge clk);
            if (t == 0) begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            if (poke && t == 3) begin
                if (s) start1 = 1'b1;
                else   start0 = 1'b1;
            end
            if (poke && t == 4) begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            if (poke && t == 5) begin
                wr_addr = 4'd0;
                wr_data = 4'hF;
                if (s) wr_en1 = 1'b1;
                else   wr_en0 = 1'b1;
            end
            if (poke && t == 6) begin
                wr_en0 = 1'b0;
                wr_en1 = 1'b0;
            end
            if (t == abort_at) begin
                reset_n = 1'b0;
                #1;
                check_zero("abort");
                sb_q.delete();
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            if (t > 0 && (t % settle) == 0) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    k = t / settle - 1;
                    if (e.mis) begin
                        exp_err++;
                        if (first < 0) first = k;
                    end
                    check_val("mismatch", 32'(m_mis), 32'(e.mis));
                    check_val("err_run",  32'(m_err), 32'((exp_err > sat) ? sat : exp_err));
                    check_val("fev_run",  32'(m_fev), 32'(first >= 0));
                end
            end else begin
                check_val("mismatch_idle", 32'(m_mis), 32'd0);
            end
            if (t < nv * settle) begin
                check_val("busy", 32'(m_busy), 32'd1);
                check_val("done_early", 32'(m_done), 32'd0);
                if (sb_q.size() > 0) check_val("dut_in", 32'(m_dut_in), 32'(sb_q[0].stim));
            end else begin
                check_val("busy_end", 32'(m_busy), 32'd0);
                check_val("done",     32'(m_done), 32'd1);
                check_val("pass",     32'(m_pass), 32'(exp_err == 0));
                check_val("err_end",  32'(m_err),  32'((exp_err > sat) ? sat : exp_err));
                check_val("fev_end",  32'(m_fev),  32'(first >= 0));
                if (first >= 0) check_val("first_idx", 32'(m_fei), 32'(first));
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en0  = 1'b0;
        wr_en1  = 1'b0;
        start0  = 1'b0;
        start1  = 1'b0;
        wr_addr = 4'd0;
        wr_data = 4'd0;
        num_vec = 5'd0;
        sel     = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset0");
        sel = 1'b1;
        #1;
        check_zero("reset1");
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) write_vec(1'b0, i, 3'(i % 8), ref_f(3'(i % 8)));
        for (int i = 0; i < 8; i++)  write_vec(1'b1, i, 3'(i), ~ref_f(3'(i)));

        run(1'b0, 8, 1, -1, 1'b0);
        run(1'b0, 0, 1, -1, 1'b0);
        run(1'b0, 20, 1, -1, 1'b0);

        write_vec(1'b0, 2, 3'd2, ~ref_f(3'd2));
        write_vec(1'b0, 5, 3'd5, ~ref_f(3'd5));
        run(1'b0, 8, 1, -1, 1'b0);

        run(1'b0, 8, 1, 4, 1'b0);
        run(1'b0, 8, 1, -1, 1'b0);

        run(1'b1, 8, 3, -1, 1'b1);
        run(1'b1, 8, 3, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_checker.md
# vector_checker

Synthesisable, parametrised self-checking test-vector engine. It holds a small vector memory of stimulus and expected response, drives the stimulus into a combinational DUT one vector at a time, and samples the DUT output after a programmable settle time. It counts mismatches and reports pass/fail. Used in on-chip bring-up and in benches as the hardware counterpart of per-vector assert-based checking, for any NI-input / NO-output function.

## Interface
Parameters:
- NI, 3, DUT input width (≥1)
- NO, 1, DUT output width (≥1)
- DEPTH, 16, vector memory entries (≥1); AW = max(1, $clog2(DEPTH))
- SETTLE, 1, cycles from applying a vector to sampling `dut_out` (≥1)
- ERRW, 8, error counter width (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  vector memory write strobe
- wr_addr  in  AW  write index
- wr_data  in  NI+NO  {stimulus[NI-1:0], expected[NO-1:0]}; stimulus in the upper bits
- num_vec  in  AW+1  number of vectors to run; values above DEPTH are clamped to DEPTH
- start  in  1  run request, level-sampled
- dut_in  out  NI  stimulus to DUT, registered
- dut_out  in  NO  DUT response
- busy  out  1  run in progress
- done  out  1  run complete; held until the next accepted start
- pass  out  1  valid when done=1; 1 iff err_count==0
- err_count  out  ERRW  mismatches, saturating at 2^ERRW−1
- mismatch  out  1  one-cycle pulse on each failing sample
- first_err_valid  out  1  at least one mismatch this run
- first_err_idx  out  AW  index of the first failing vector

## Operation
- States: IDLE, RUN, DONE. On reset: IDLE, all outputs 0, dut_in=0, internal idx/timer=0. Vector memory is not reset.
- Writes take effect only in IDLE or DONE (busy=0). wr_en while busy is ignored.
- start in IDLE or DONE is accepted. Acceptance clears err_count, first_err_*, done and pass.
  - If the clamped num_vec is 0: go to DONE with pass=1.
  - Otherwise: dut_in←mem[0].stimulus, idx←0, timer←SETTLE−1, go to RUN (busy=1).
- start while in RUN is ignored.
- RUN, timer≠0: timer decrements; dut_in holds.
- RUN, timer==0 (sampling edge): compare dut_out against mem[idx].expected.
  - Any differing bit is a mismatch; X/Z on dut_out also counts as a mismatch.
  - On mismatch: mismatch=1 for the next cycle, err_count increments (saturating). If first_err_valid=0, set first_err_valid←1 and first_err_idx←idx.
  - If idx==N−1: go to DONE; busy←0, done←1, pass←(final err_count==0, including this sample).
  - Else: idx++, dut_in←mem[idx+1].stimulus, timer←SETTLE−1.
- DONE: dut_in holds the last vector. Results are stable until the next start or reset.
- Reset assertion mid-run aborts immediately (asynchronous). Every output returns to 0 and the state goes to IDLE.

## Timing
- Define edge 0 as the edge that accepts start. dut_in shows vector k from edge k·SETTLE.
- Vector k is sampled at edge (k+1)·SETTLE.
- done/busy transition at edge N·SETTLE. Total run latency is N·SETTLE cycles.
- When num_vec is 0, done=1 after edge 0.
- mismatch, err_count and first_err_* update at the sampling edge.
- The DUT combinational path from dut_in to dut_out must settle within SETTLE cycles.
- Memory read is combinational from the internal array, so there is no extra pipeline latency.

## Test plan
Reference DUT for all scenarios: y = (~b&~c)|(a&~b), with dut_in={a,b,c}. Correct expected values for inputs 000..111 are 1,0,0,0,1,1,0,0.
- Clean run: load the 8 correct vectors, num_vec=8, SETTLE=1, start → busy edges 0–7, done=1 and pass=1 after edge 8, err_count=0, mismatch never asserted.
- Injected failures: expected at idx 2 and 5 inverted → mismatch pulses after edges 3 and 6, err_count=2, first_err_idx=2, first_err_valid=1, pass=0.
- Edge cases: num_vec=0 → done=1, pass=1 after edge 0. num_vec=20 with DEPTH=16 → 16 vectors run, done after edge 16.
- Saturation: ERRW=2, all 8 expected values inverted → err_count=3, first_err_idx=0, mismatch pulsed 8 times.
- Settle timing: SETTLE=3 → dut_in changes every 3 cycles, done after edge 24. start during RUN and wr_en during RUN are both ignored: results are unchanged and the memory is intact.
- Reset mid-run: reset_n low while idx=4 → outputs are 0 immediately. After release, start reruns from idx 0 with the same memory contents and the same results.
